decode_rdctrl: RTL and testbench

- Flow controller for the decode register-read / rename-read stage.
- Holds the operand bundle (two 32-bit regfile values plus two RAT src valid/ROB tags) in a 2-entry in-order skid buffer under downstream backpressure.
- Wakes held operands from the ROB writeback broadcast.
- Flushes on bco_valid; freezes for one cycle on snoop_hit.
- Sits between the regfile/RAT read outputs and the dispatch/issue stage.

---
 rtl/decode_rdctrl.sv | 137 +++++++++++++
 tb/tb_decode_rdctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_rdctrl.sv
// Register-read / rename-read stage flow controller: 2-entry in-order skid buffer with ROB writeback wakeup.
// Latency 1 cycle accept->o_valid when empty; o_ready drops at 2 entries, on snoop_hit freeze, and on bco_valid flush.
module decode_rdctrl #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              snoop_hit,
  input  logic              bco_valid,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_regfs_data0,
  input  logic [DATA_W-1:0] i_regfs_data1,
  input  logic              i_rat_src0_valid,
  input  logic [ROB_W-1:0]  i_rat_src0_rob,
  input  logic              i_rat_src1_valid,
  input  logic [ROB_W-1:0]  i_rat_src1_rob,
  input  logic              i_wb_valid,
  input  logic [ROB_W-1:0]  i_wb_rob,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_regfs_data0,
  output logic [DATA_W-1:0] o_regfs_data1,
  output logic              o_rat_src0_valid,
  output logic [ROB_W-1:0]  o_rat_src0_rob,
  output logic              o_rat_src1_valid,
  output logic [ROB_W-1:0]  o_rat_src1_rob,
  output logic [1:0]        o_occupancy
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              src0_vld;
    logic [ROB_W-1:0]  src0_rob;
    logic              src1_vld;
    logic [ROB_W-1:0]  src1_rob;
  } entry_t;

  state_t     state_q;
  logic [1:0] occ_q;
  entry_t     head_q, tail_q;
  entry_t     in_ent, in_wk, head_wk, tail_wk;
  logic       accept, fire;

  // Unrenamed sources never match; the tag is kept after wakeup.
  function automatic entry_t wake(entry_t e, logic wb_v, logic [ROB_W-1:0] wb_rob,
                                  logic [DATA_W-1:0] wb_data);
    entry_t r;
    r = e;
    if (e.src0_vld && wb_v && (e.src0_rob == wb_rob)) begin
      r.data0    = wb_data;
      r.src0_vld = 1'b0;
    end
    if (e.src1_vld && wb_v && (e.src1_rob == wb_rob)) begin
      r.data1    = wb_data;
      r.src1_vld = 1'b0;
    end
    return r;
  endfunction

  assign in_ent = '{data0: i_regfs_data0, data1: i_regfs_data1,
                    src0_vld: i_rat_src0_valid, src0_rob: i_rat_src0_rob,
                    src1_vld: i_rat_src1_valid, src1_rob: i_rat_src1_rob};

  assign in_wk   = wake(in_ent, i_wb_valid, i_wb_rob, i_wb_data);
  assign head_wk = wake(head_q, i_wb_valid, i_wb_rob, i_wb_data);
  assign tail_wk = wake(tail_q, i_wb_valid, i_wb_rob, i_wb_data);

  assign o_ready = (state_q != TWO)   && !snoop_hit && !bco_valid;
  assign o_valid = (state_q != EMPTY) && !snoop_hit && !bco_valid;
  assign accept  = i_valid && o_ready;
  assign fire    = o_valid && i_ready;

  assign o_regfs_data0    = head_q.data0;
  assign o_regfs_data1    = head_q.data1;
  assign o_rat_src0_valid = head_q.src0_vld;
  assign o_rat_src0_rob   = head_q.src0_rob;
  assign o_rat_src1_valid = head_q.src1_vld;
  assign o_rat_src1_rob   = head_q.src1_rob;
  assign o_occupancy      = occ_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= EMPTY;
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (bco_valid) begin
      state_q <= EMPTY;
      occ_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // Held entries always absorb the broadcast; a freeze simply blocks accept/fire.
      head_q <= head_wk;
      tail_q <= tail_wk;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_q  <= in_wk;
            state_q <= ONE;
            occ_q   <= 2'd1;
          end
        end
        ONE: begin
          if (accept && !fire) begin
            tail_q  <= in_wk;
            state_q <= TWO;
            occ_q   <= 2'd2;
          end else if (fire && !accept) begin
            state_q <= EMPTY;
            occ_q   <= 2'd0;
          end else if (accept && fire) begin
            head_q <= in_wk;
          end
        end
        TWO: begin
          if (fire) begin
            head_q  <= tail_wk;
            state_q <= ONE;
            occ_q   <= 2'd1;
          end
        end
        default: begin
          state_q <= EMPTY;
          occ_q   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_rdctrl.sv
// Bench for decode_rdctrl: directed vector table, reset-in-flight sequence, then random traffic vs a queue model.
module tb_decode_rdctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        snoop_hit, bco_valid, i_valid, o_ready;
  logic [31:0] i_regfs_data0, i_regfs_data1;
  logic        i_rat_src0_valid, i_rat_src1_valid;
  logic [3:0]  i_rat_src0_rob, i_rat_src1_rob;
  logic        i_wb_valid;
  logic [3:0]  i_wb_rob;
  logic [31:0] i_wb_data;
  logic        o_valid, i_ready;
  logic [31:0] o_regfs_data0, o_regfs_data1;
  logic        o_rat_src0_valid, o_rat_src1_valid;
  logic [3:0]  o_rat_src0_rob, o_rat_src1_rob;
  logic [1:0]  o_occupancy;

  always #5 clk = ~clk;

  decode_rdctrl #(.DATA_W(32), .ROB_W(4)) dut (
    .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_regfs_data0(i_regfs_data0), .i_regfs_data1(i_regfs_data1),
    .i_rat_src0_valid(i_rat_src0_valid), .i_rat_src0_rob(i_rat_src0_rob),
    .i_rat_src1_valid(i_rat_src1_valid), .i_rat_src1_rob(i_rat_src1_rob),
    .i_wb_valid(i_wb_valid), .i_wb_rob(i_wb_rob), .i_wb_data(i_wb_data),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_regfs_data0(o_regfs_data0), .o_regfs_data1(o_regfs_data1),
    .o_rat_src0_valid(o_rat_src0_valid), .o_rat_src0_rob(o_rat_src0_rob),
    .o_rat_src1_valid(o_rat_src1_valid), .o_rat_src1_rob(o_rat_src1_rob),
    .o_occupancy(o_occupancy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic iv; logic [31:0] d0; logic v0; logic [3:0] r0;
    logic [31:0] d1; logic v1; logic [3:0] r1;
    logic rdy, snp, bco, wbv; logic [3:0] wbr; logic [31:0] wbd;
    logic e_ov, e_ordy; logic [1:0] e_occ;
    logic [31:0] e_d0; logic e_v0; logic [3:0] e_r0;
    logic [31:0] e_d1; logic e_v1; logic [3:0] e_r1;
  } vec_t;

  function automatic vec_t vi(logic iv, logic [31:0] d0, logic v0, logic [3:0] r0,
                              logic [31:0] d1, logic v1, logic [3:0] r1, logic rdy,
                              logic snp, logic bco, logic wbv, logic [3:0] wbr, logic [31:0] wbd);
    vec_t v;
    v = '{default: '0};
    v.iv = iv; v.d0 = d0; v.v0 = v0; v.r0 = r0; v.d1 = d1; v.v1 = v1; v.r1 = r1;
    v.rdy = rdy; v.snp = snp; v.bco = bco; v.wbv = wbv; v.wbr = wbr; v.wbd = wbd;
    return v;
  endfunction

  function automatic vec_t ex(vec_t vin, logic ov, logic ordy, logic [1:0] occ,
                              logic [31:0] d0, logic v0, logic [3:0] r0,
                              logic [31:0] d1, logic v1, logic [3:0] r1);
    vec_t v;
    v = vin;
    v.e_ov = ov; v.e_ordy = ordy; v.e_occ = occ;
    v.e_d0 = d0; v.e_v0 = v0; v.e_r0 = r0; v.e_d1 = d1; v.e_v1 = v1; v.e_r1 = r1;
    return v;
  endfunction

  task automatic drive(vec_t v);
    i_valid = v.iv; i_regfs_data0 = v.d0; i_rat_src0_valid = v.v0; i_rat_src0_rob = v.r0;
    i_regfs_data1 = v.d1; i_rat_src1_valid = v.v1; i_rat_src1_rob = v.r1;
    i_ready = v.rdy; snoop_hit = v.snp; bco_valid = v.bco;
    i_wb_valid = v.wbv; i_wb_rob = v.wbr; i_wb_data = v.wbd;
  endtask

  task automatic chk_head(string tag, logic [31:0] d0, logic v0, logic [3:0] r0,
                          logic [31:0] d1, logic v1, logic [3:0] r1);
    chk({tag, ".data0"}, o_regfs_data0, d0);
    chk({tag, ".src0_valid"}, {31'd0, o_rat_src0_valid}, {31'd0, v0});
    chk({tag, ".src0_rob"}, {28'd0, o_rat_src0_rob}, {28'd0, r0});
    chk({tag, ".data1"}, o_regfs_data1, d1);
    chk({tag, ".src1_valid"}, {31'd0, o_rat_src1_valid}, {31'd0, v1});
    chk({tag, ".src1_rob"}, {28'd0, o_rat_src1_rob}, {28'd0, r1});
  endtask

  // Reference model: an ordered list of held bundles.
  typedef struct {
    logic [31:0] d0, d1; logic v0, v1; logic [3:0] r0, r1;
  } bun_t;

  bun_t mq[$];

  function automatic bun_t wk(bun_t b, logic wv, logic [3:0] wr, logic [31:0] wd);
    bun_t r;
    r = b;
    if (b.v0 && wv && b.r0 == wr) begin r.d0 = wd; r.v0 = 1'b0; end
    if (b.v1 && wv && b.r1 == wr) begin r.d1 = wd; r.v1 = 1'b0; end
    return r;
  endfunction

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    drive(idle);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset.o_valid", {31'd0, o_valid}, 32'd0);
    chk("reset.occupancy", {30'd0, o_occupancy}, 32'd0);
    chk_head("reset", 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;

    // Basic pass-through
    tbl.push_back(ex(vi(1, 'h1234, 0, 0, 'h5678, 1, 4, 1, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 1, 1, 'h1234, 0, 0, 'h5678, 1, 4));
    tbl.push_back(ex(idle, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Backpressure: A, B held, C waits upstream
    tbl.push_back(ex(vi(1, 'hA0, 0, 0, 'hA1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(vi(1, 'hB0, 0, 0, 'hB1, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1, 'hA0, 0, 0, 'hA1, 0, 0));
    tbl.push_back(ex(vi(1, 'hC0, 0, 0, 'hC1, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 2, 'hA0, 0, 0, 'hA1, 0, 0));
    tbl.push_back(ex(vi(1, 'hC0, 0, 0, 'hC1, 0, 0, 1, 0, 0, 0, 0, 0), 1, 0, 2, 'hA0, 0, 0, 'hA1, 0, 0));
    tbl.push_back(ex(vi(1, 'hC0, 0, 0, 'hC1, 0, 0, 1, 0, 0, 0, 0, 0), 1, 1, 1, 'hB0, 0, 0, 'hB1, 0, 0));
    tbl.push_back(ex(idle, 1, 1, 1, 'hC0, 0, 0, 'hC1, 0, 0));
    tbl.push_back(ex(idle, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Wakeup of a held entry; non-matching tag first
    tbl.push_back(ex(vi(1, 'h11, 1, 7, 'h22, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 'h66), 1, 1, 1, 'h11, 1, 7, 'h22, 0, 0));
    tbl.push_back(ex(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 'hDEADBEEF), 1, 1, 1, 'h11, 1, 7, 'h22, 0, 0));
    tbl.push_back(ex(idle, 1, 1, 1, 'hDEADBEEF, 0, 7, 'h22, 0, 0));
    tbl.push_back(ex(idle, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Capture bypass
    tbl.push_back(ex(vi(1, 'h33, 0, 0, 'h44, 1, 3, 0, 0, 0, 1, 3, 'hCAFE), 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 1, 1, 'h33, 0, 0, 'hCAFE, 0, 3));
    tbl.push_back(ex(idle, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Flush at occupancy 2 drops the offered bundle
    tbl.push_back(ex(vi(1, 'h51, 0, 0, 'h52, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(vi(1, 'h61, 0, 0, 'h62, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 1, 'h51, 0, 0, 'h52, 0, 0));
    tbl.push_back(ex(vi(1, 'h99, 0, 0, 'h98, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Snoop freeze for one cycle
    tbl.push_back(ex(vi(1, 'h77, 0, 0, 'h78, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(vi(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(idle, 1, 1, 1, 'h77, 0, 0, 'h78, 0, 0));
    tbl.push_back(ex(idle, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k]);
      #1;
      chk($sformatf("vec%0d.o_valid", k), {31'd0, o_valid}, {31'd0, tbl[k].e_ov});
      chk($sformatf("vec%0d.o_ready", k), {31'd0, o_ready}, {31'd0, tbl[k].e_ordy});
      chk($sformatf("vec%0d.occupancy", k), {30'd0, o_occupancy}, {30'd0, tbl[k].e_occ});
      if (tbl[k].e_ov)
        chk_head($sformatf("vec%0d", k), tbl[k].e_d0, tbl[k].e_v0, tbl[k].e_r0,
                 tbl[k].e_d1, tbl[k].e_v1, tbl[k].e_r1);
    end

    // Reset asserted between clock edges clears the stage at once
    @(negedge clk);
    drive(vi(1, 'hAB, 0, 0, 'hCD, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rstmid.pre_valid", {31'd0, o_valid}, 32'd1);
    chk("rstmid.pre_occ", {30'd0, o_occupancy}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("rstmid.o_valid", {31'd0, o_valid}, 32'd0);
    chk("rstmid.occupancy", {30'd0, o_occupancy}, 32'd0);
    chk("rstmid.data0", o_regfs_data0, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    mq.delete();

    // Random traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      bun_t inb;
      logic e_ov, e_ordy, acc, fr;
      v = vi($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 4'($urandom_range(0, 3)),
             $urandom, $urandom_range(0, 1), 4'($urandom_range(0, 3)),
             ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) < 4), 4'($urandom_range(0, 3)), $urandom);
      @(negedge clk);
      drive(v);
      #1;
      e_ov   = (mq.size() > 0) && !v.snp && !v.bco;
      e_ordy = (mq.size() < 2) && !v.snp && !v.bco;
      chk("rnd.o_valid", {31'd0, o_valid}, {31'd0, e_ov});
      chk("rnd.o_ready", {31'd0, o_ready}, {31'd0, e_ordy});
      chk("rnd.occupancy", {30'd0, o_occupancy}, mq.size());
      if (e_ov)
        chk_head("rnd", mq[0].d0, mq[0].v0, mq[0].r0, mq[0].d1, mq[0].v1, mq[0].r1);

      if (v.bco) begin
        mq.delete();
      end else begin
        acc = v.iv && e_ordy;
        fr  = e_ov && v.rdy;
        foreach (mq[j]) mq[j] = wk(mq[j], v.wbv, v.wbr, v.wbd);
        if (fr) void'(mq.pop_front());
        if (acc) begin
          inb.d0 = v.d0; inb.v0 = v.v0; inb.r0 = v.r0;
          inb.d1 = v.d1; inb.v1 = v.v1; inb.r1 = v.r1;
          mq.push_back(wk(inb, v.wbv, v.wbr, v.wbd));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
